pattern_scan_scheduler: RTL

Shares one bit-serial pattern detector (sequence 1-0-0-0-1, MSB first, overlapping) between N_REQ requesters. Each requester hands over a FRAME_W-bit frame through a valid/ready handshake. The scheduler arbitrates, serializes the granted frame into the detector one bit per clock, counts matches, and returns a tagged result through a valid/ready handshake. It sits between the frame producers and any consumer of pattern statistics.

---
 rtl/pattern_scan_pkg.sv | 12 +
 rtl/bit_pattern_detector.sv | 42 ++++
 rtl/pattern_scan_scheduler.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/pattern_scan_pkg.sv
// Shared types and constants for the pattern scan scheduler and its bit-serial detector.
package pattern_scan_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  localparam int unsigned PATTERN_LEN = 5;
  localparam logic [PATTERN_LEN-1:0] PATTERN = 5'b10001;

  // Named after the prefix of PATTERN matched so far.
  typedef enum logic [2:0] {S_IDLE, S_1, S_10, S_100, S_1000} det_state_e;

endpackage

// File: rtl/bit_pattern_detector.sv
// Overlapping Mealy detector for PATTERN (1-0-0-0-1, first bit first).
// A synchronous clear returns it to S_IDLE so patterns never span frames.
module bit_pattern_detector
  import pattern_scan_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic bit_valid,
  input  logic bit_in,
  output logic match
);

  det_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    match   = 1'b0;
    if (clr) begin
      state_d = S_IDLE;
    end else if (bit_valid) begin
      unique case (state_q)
        S_IDLE:  state_d = bit_in ? S_1 : S_IDLE;
        S_1:     state_d = bit_in ? S_1 : S_10;
        S_10:    state_d = bit_in ? S_1 : S_100;
        S_100:   state_d = bit_in ? S_1 : S_1000;
        S_1000: begin
          // The closing 1 doubles as the opening 1 of the next pattern.
          match   = (bit_in == PATTERN[0]);
          state_d = bit_in ? S_1 : S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

endmodule

// File: rtl/pattern_scan_scheduler.sv
// Arbitrates N_REQ frame producers onto one serial pattern detector and returns tagged counts.
// Define PATTERN_SCAN_RR_EN for round-robin arbitration; otherwise the lowest index wins.
module pattern_scan_scheduler
  import pattern_scan_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned FRAME_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*FRAME_W-1:0]     req_data,
  output logic [N_REQ-1:0]             req_ready,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [$clog2(N_REQ)-1:0]     res_id,
  output logic [$clog2(FRAME_W+1)-1:0] res_count,
  output logic                         res_hit,
  output logic                         busy
);

  localparam int unsigned IdW  = $clog2(N_REQ);
  localparam int unsigned CntW = $clog2(FRAME_W + 1);
  localparam int unsigned BitW = $clog2(FRAME_W);
  localparam logic [BitW-1:0] LastBit = BitW'(FRAME_W - 1);

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [BitW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [IdW-1:0]     id_q, id_d;

  logic               gnt_any;
  logic [IdW-1:0]     gnt_idx;
  logic [FRAME_W-1:0] gnt_frame;
  logic               load;
  logic               bit_valid;
  logic               match;

`ifdef PATTERN_SCAN_RR_EN
  logic [IdW-1:0] ptr_q, ptr_d;
  logic [IdW-1:0] rr_idx;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    rr_idx  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      rr_idx = IdW'((32'(ptr_q) + k) % N_REQ);
      if (!gnt_any && req_valid[rr_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = rr_idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (load) ptr_d = (gnt_idx == IdW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!gnt_any && req_valid[k]) begin
        gnt_any = 1'b1;
        gnt_idx = IdW'(k);
      end
    end
  end
`endif

  always_comb begin
    gnt_frame = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (gnt_idx == IdW'(k)) gnt_frame = req_data[k*FRAME_W +: FRAME_W];
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    load      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          load      = 1'b1;
          shreg_d   = gnt_frame;
          id_d      = gnt_idx;
          cnt_d     = '0;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d   = {shreg_q[FRAME_W-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (match) cnt_d = cnt_q + 1'b1;
        if (bit_cnt_q == LastBit) state_d = DONE;
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
      id_q      <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
    end
  end

  assign bit_valid = (state_q == SHIFT);

  bit_pattern_detector u_detector (
    .clk       (clk),
    .rst       (rst),
    .clr       (load),
    .bit_valid (bit_valid),
    .bit_in    (shreg_q[FRAME_W-1]),
    .match     (match)
  );

  assign res_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign res_id    = id_q;
  assign res_count = cnt_q;
  assign res_hit   = |cnt_q;

endmodule
